// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT stage sequencer and its helpers:
// FSM encoding, twiddle addressing modes and default bank geometry.
package ntt_pkg;

    // Default geometry of the NTT bank.
    localparam int unsigned DEF_LOG_N          = 12;
    localparam int unsigned DEF_LOG_CORE_COUNT = 5;   // must match the ntt_core instances
    localparam int unsigned DEF_ADDR_W         = 9;

    // Fixed widths of the shared control outputs.
    localparam int unsigned LOG_M_W = 4;
    localparam int unsigned I_W     = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_SAME_TW = 2'd0,
        MODE_GROUP   = 2'd1,
        MODE_PAIR    = 2'd2
    } mode_e;

    // Twiddle addressing mode used by the cores for a given stage.
    function automatic mode_e stage_mode(input logic [LOG_M_W-1:0] log_m,
                                         input int unsigned mode1_stage,
                                         input int unsigned mode2_stage);
        if (32'(log_m) < mode1_stage) begin
            return MODE_SAME_TW;
        end else if (32'(log_m) < mode2_stage) begin
            return MODE_GROUP;
        end
        return MODE_PAIR;
    endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Fixed-depth shift register with synchronous clear; output lags input
// by exactly DEPTH clock cycles.
module ntt_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one position per cycle; reset empties every slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this storage is cleared on reset on purpose -- it carries a
            // write strobe, and any stale slot would fire a write after reset.
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_sequencer.sv
// Steps one NTT through its LOG_N butterfly stages: per stage it sweeps the
// shared BRAM read address, drives log_m/mode/i for the twiddle lookup and
// writes results back to the same addresses WR_DELAY cycles later. A stage
// does not start until the previous stage's last write has landed.
module ntt_stage_sequencer
    import ntt_pkg::*;
#(
    parameter int unsigned LOG_N       = DEF_LOG_N,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned WORDS       = 32,
    parameter int unsigned MODE1_STAGE = 5,
    parameter int unsigned MODE2_STAGE = 7,
    parameter int unsigned WR_DELAY    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [LOG_M_W-1:0] log_m_o,
    output logic [1:0]         mode_o,
    output logic [I_W-1:0]     i_o,
    output logic [ADDR_W-1:0]  read_adress_o,
    output logic               write_enable_o,
    output logic [ADDR_W-1:0]  upper_write_address_o,
    output logic [ADDR_W-1:0]  lower_write_address_o
);

    localparam int unsigned        DRAIN_W    = $clog2(WR_DELAY + 1);
    localparam logic [ADDR_W-1:0]  LAST_WORD  = ADDR_W'(WORDS - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(WR_DELAY - 1);
    localparam logic [LOG_M_W-1:0] LAST_STAGE = LOG_M_W'(LOG_N - 1);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [LOG_M_W-1:0]   log_m_q, log_m_d;
    mode_e                mode_q, mode_d;
    logic                 read_valid;
    logic [ADDR_W-1:0]    rd_addr;
    logic [LOG_M_W-1:0]   i_shift;
    logic [ADDR_W:0]      wb_in, wb_out;

    // State, counters and stage controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: registers are updated with non-blocking (<=) so every
            // flop in this block samples the values from before the edge.
            state_q     <= S_IDLE;
            rd_cnt_q    <= '0;
            drain_cnt_q <= '0;
            log_m_q     <= '0;
            mode_q      <= MODE_SAME_TW;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            log_m_q     <= log_m_d;
            mode_q      <= mode_d;
        end
    end

    // Next-state logic: read sweep, drain until the last write, then next stage.
    always_comb begin
        // NOTE: every signal gets its default before the case, so no path
        // leaves one unassigned and no latch can be inferred.
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        drain_cnt_d = drain_cnt_q;
        log_m_d     = log_m_q;
        read_valid  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    rd_cnt_d = '0;
                    log_m_d  = '0;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                read_valid = 1'b1;
                if (rd_cnt_q == LAST_WORD) begin
                    drain_cnt_d = '0;
                    state_d     = S_DRAIN;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == LAST_DRAIN) begin
                    if (log_m_q == LAST_STAGE) begin
                        state_d = S_DONE;
                    end else begin
                        log_m_d  = log_m_q + 1'b1;
                        rd_cnt_d = '0;
                        state_d  = S_READ;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Mode moves with log_m, so it is fixed for the whole stage.
        mode_d = stage_mode(log_m_d, MODE1_STAGE, MODE2_STAGE);
    end

    // Address and group index: live during READ, held through DRAIN, zero otherwise.
    always_comb begin
        rd_addr = ((state_q == S_READ) || (state_q == S_DRAIN)) ? rd_cnt_q : '0;
        i_shift = LOG_M_W'(MODE2_STAGE) - log_m_q;
        i_o     = (mode_q == MODE_GROUP) ? I_W'(rd_addr >> i_shift) : '0;
    end

    // Write-back: the read strobe and address arrive WR_DELAY cycles later.
    assign wb_in = {read_valid, rd_addr};

    ntt_delay_line #(
        .WIDTH (ADDR_W + 1),
        .DEPTH (WR_DELAY)
    ) u_wb_delay (
        .clk (clk),
        .rst (rst),
        .d_i (wb_in),
        .q_o (wb_out)
    );

    assign write_enable_o        = wb_out[ADDR_W];
    assign upper_write_address_o = wb_out[ADDR_W-1:0];
    assign lower_write_address_o = wb_out[ADDR_W-1:0];
    assign read_adress_o         = rd_addr;
    assign log_m_o               = log_m_q;
    assign mode_o                = mode_q;
    assign busy_o                = (state_q != S_IDLE);
    assign done_o                = (state_q == S_DONE);

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Scoreboard bench for ntt_stage_sequencer: stimulus pushes the expected read,
// write and done schedule of each accepted start; a negedge monitor pops and
// compares as the DUT presents reads, writes and done.
module tb_ntt_stage_sequencer;

    localparam int ADDR_W    = 9;
    localparam int WORDS     = 32;
    localparam int WR_DELAY  = 6;
    localparam int LOG_N     = 12;
    localparam int STAGE_CYC = 38;   // WORDS + WR_DELAY
    localparam int RUN_CYC   = 457;  // 1 + 12 * 38

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy, done, write_enable;
    logic [3:0]        log_m;
    logic [1:0]        mode;
    logic [9:0]        i_idx;
    logic [ADDR_W-1:0] read_adress, upper_wa, lower_wa;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { int cyc; logic [ADDR_W-1:0] addr; } wr_t;
    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        lm;
        logic [1:0]        md;
        logic [9:0]        iv;
    } rd_t;

    wr_t wr_q[$];
    rd_t rd_q[$];
    int  done_q[$];

    int         busy_lo = 1;
    int         busy_hi = 0;
    bit         mon_en  = 1'b0;
    int         last_we = -100;
    logic [3:0] prev_lm = '0;
    wr_t        mw;
    rd_t        mr;
    int         md_cyc;

    ntt_stage_sequencer dut (
        .clk                   (clk),
        .rst                   (rst),
        .start_i               (start),
        .busy_o                (busy),
        .done_o                (done),
        .log_m_o               (log_m),
        .mode_o                (mode),
        .i_o                   (i_idx),
        .read_adress_o         (read_adress),
        .write_enable_o        (write_enable),
        .upper_write_address_o (upper_wa),
        .lower_write_address_o (lower_wa)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    function automatic logic [1:0] exp_mode(input int s);
        if (s < 5) return 2'd0;
        if (s < 7) return 2'd1;
        return 2'd2;
    endfunction

    // Push the full schedule of a run whose start is high in cycle t0.
    task automatic push_run(input int t0);
        rd_t r;
        wr_t w;
        for (int s = 0; s < LOG_N; s++) begin
            for (int k = 0; k < WORDS; k++) begin
                r.cyc  = t0 + 1 + s * STAGE_CYC + k;
                r.addr = ADDR_W'(k);
                r.lm   = 4'(s);
                r.md   = exp_mode(s);
                r.iv   = (r.md == 2'd1) ? 10'(k >> (7 - s)) : 10'd0;
                rd_q.push_back(r);
                w.cyc  = r.cyc + WR_DELAY;
                w.addr = ADDR_W'(k);
                wr_q.push_back(w);
            end
        end
        done_q.push_back(t0 + RUN_CYC);
        busy_lo = t0 + 1;
        busy_hi = t0 + RUN_CYC;
    endtask

    task automatic start_run(output int t0);
        t0 = cyc;
        push_run(t0);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Monitor: compare every read, write, done and busy the DUT presents.
    always @(negedge clk) begin
        if (mon_en) begin
            while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                mr = rd_q.pop_front();
                check("rd_missing", cyc, mr.cyc);
            end
            if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                mr = rd_q.pop_front();
                check("rd_addr", read_adress, mr.addr);
                check("rd_log_m", log_m, mr.lm);
                check("rd_mode", mode, mr.md);
                check("rd_i", i_idx, mr.iv);
            end

            while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
                mw = wr_q.pop_front();
                check("wr_missing", cyc, mw.cyc);
            end
            if (write_enable === 1'b1) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", wr_q.size(), 1);
                end else begin
                    mw = wr_q.pop_front();
                    check("wr_cycle", cyc, mw.cyc);
                    check("wr_upper", upper_wa, mw.addr);
                    check("wr_lower", lower_wa, mw.addr);
                end
                last_we = cyc;
            end

            while (done_q.size() > 0 && done_q[0] < cyc) begin
                md_cyc = done_q.pop_front();
                check("done_missing", cyc, md_cyc);
            end
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", done_q.size(), 1);
                end else begin
                    md_cyc = done_q.pop_front();
                    check("done_cycle", cyc, md_cyc);
                end
            end

            check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);

            if (log_m !== prev_lm && log_m != 4'd0) begin
                check("raw_gap", cyc - last_we, 1);
            end
            prev_lm = log_m;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, t0b, t0c, we_cnt;
        rst   = 1'b1;
        start = 1'b0;

        // 1. Reset then idle.
        repeat (3) tick();
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_log_m", log_m, 0);
        check("rst_mode", mode, 0);
        check("rst_i", i_idx, 0);
        check("rst_rd_addr", read_adress, 0);
        check("rst_we", write_enable, 0);
        check("rst_upper", upper_wa, 0);
        check("rst_lower", lower_wa, 0);
        we_cnt = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (write_enable !== 1'b0) we_cnt++;
        end
        check("idle_we_count", we_cnt, 0);
        tick();

        // 2-5. Full run with ignored start pulses and hand-picked spot checks.
        start_run(t0);
        wait_until(t0 + 7);
        @(negedge clk);
        check("first_write_we", write_enable, 1);
        check("first_write_addr", upper_wa, 0);
        wait_until(t0 + 32);
        @(negedge clk);
        check("stage0_last_read", read_adress, 31);
        wait_until(t0 + 39);
        @(negedge clk);
        check("stage1_first_log_m", log_m, 1);
        check("stage1_first_addr", read_adress, 0);
        wait_until(t0 + 100);
        pulse_start();
        wait_until(t0 + 165);
        @(negedge clk);
        check("lm4_mode", mode, 0);
        check("lm4_i", i_idx, 0);
        wait_until(t0 + 203);
        @(negedge clk);
        check("lm5_mode", mode, 1);
        check("lm5_rd12_i", i_idx, 3);
        wait_until(t0 + 241);
        @(negedge clk);
        check("lm6_mode", mode, 1);
        check("lm6_rd12_i", i_idx, 6);
        wait_until(t0 + 279);
        @(negedge clk);
        check("lm7_mode", mode, 2);
        check("lm7_i", i_idx, 0);
        wait_until(t0 + 457);
        start = 1'b1;
        @(negedge clk);
        check("done_at_457", done, 1);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("idle_458_busy", busy, 0);
        check("idle_458_done", done, 0);
        wait_until(t0 + 480);
        @(negedge clk);
        check("no_second_run", busy, 0);
        tick();

        // 6. Reset mid-run, then restart.
        start_run(t0b);
        wait_until(t0b + 200);
        rst     = 1'b1;
        busy_hi = t0b + 200;
        while (rd_q.size() > 0 && rd_q[$].cyc > t0b + 200) void'(rd_q.pop_back());
        while (wr_q.size() > 0 && wr_q[$].cyc > t0b + 200) void'(wr_q.pop_back());
        while (done_q.size() > 0) void'(done_q.pop_back());
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_we", write_enable, 0);
        check("abort_log_m", log_m, 0);
        wait_until(t0b + 205);
        start_run(t0c);
        wait_until(t0c + 457);
        @(negedge clk);
        check("restart_done", done, 1);
        check("restart_done_offset", cyc - t0b, 662);
        repeat (5) tick();
        @(negedge clk);

        check("rd_q_empty", rd_q.size(), 0);
        check("wr_q_empty", wr_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
